// File: rtl/box_hit_judge.sv
// rtl/box_hit_judge.sv - whack-a-box round judge: show a target, judge the pad hit, flash result, keep score
//
// Purpose:
//   Accepts a target box (1..5) while idle, opens a hit window of WINDOW_CYCLES
//   cycles, judges the first rising edge on the pad inputs (or a timeout),
//   then shows the result for FLASH_CYCLES cycles before returning to idle.
//
// Optional build macro:
//   MISS_PENALTY_EN - when defined, each miss decrements the score (floor 0).
//
// Ports:
//   CLOCK_50      in   system clock
//   reset_signal  in   synchronous active-high reset
//   box_valid     in   pulse: box carries a new target
//   box[2:0]      in   target index, legal 1..5
//   hit[4:0]      in   synchronised level pad inputs, bit i-1 = box i
//   box_ready     out  high while idle
//   active_box    out  target currently shown, 0 when none
//   result_valid  out  high for the whole result display
//   result_hit    out  result display: 1 = hit, 0 = miss
//   hit_pulse     out  one-cycle strobe on a correct hit
//   miss_pulse    out  one-cycle strobe on a miss (timeout or wrong pad)
//   score         out  running score, saturating

module box_hit_judge #(
  parameter int WINDOW_CYCLES = 50000000,
  parameter int FLASH_CYCLES  = 12500000,
  parameter int SCORE_W       = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset_signal,
  input  logic               box_valid,
  input  logic [2:0]         box,
  input  logic [4:0]         hit,
  output logic               box_ready,
  output logic [2:0]         active_box,
  output logic               result_valid,
  output logic               result_hit,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score
);

  // Guard the degenerate 1-cycle case so counters never get zero width.
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FLS_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [FLS_W-1:0]   FLS_LAST  = FLS_W'(FLASH_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         active_box_q, active_box_d;
  logic [4:0]         hit_prev_q, hit_prev_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [FLS_W-1:0]   flash_cnt_q, flash_cnt_d;
  logic               result_hit_q, result_hit_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [4:0] rise;
  logic [4:0] target_mask;
  logic       correct_hit;
  logic       wrong_pad;
  logic       timeout;

  // Only meaningful in ACTIVE, where active_box_q is always 1..5.
  assign rise        = hit & ~hit_prev_q;
  assign target_mask = 5'b00001 << (active_box_q - 3'd1);
  assign correct_hit = (rise == target_mask);
  assign wrong_pad   = |(rise & ~target_mask);
  assign timeout     = (win_cnt_q == WIN_LAST);

  always_comb begin
    state_d      = state_q;
    active_box_d = active_box_q;
    hit_prev_d   = hit;
    win_cnt_d    = win_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    result_hit_d = result_hit_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    score_d      = score_q;

    case (state_q)
      IDLE: begin
        if (box_valid && (box >= 3'd1) && (box <= 3'd5)) begin
          state_d      = ACTIVE;
          active_box_d = box;
          win_cnt_d    = '0;
        end
      end

      ACTIVE: begin
        win_cnt_d = win_cnt_q + 1'b1;
        // A correct hit is tested first so it beats a same-cycle timeout.
        if (correct_hit) begin
          state_d      = RESULT;
          flash_cnt_d  = '0;
          result_hit_d = 1'b1;
          hit_pulse_d  = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
        end else if (wrong_pad || timeout) begin
          state_d      = RESULT;
          flash_cnt_d  = '0;
          result_hit_d = 1'b0;
          miss_pulse_d = 1'b1;
`ifdef MISS_PENALTY_EN
          if (score_q != '0) score_d = score_q - 1'b1;
`else
          score_d = score_q;
`endif
        end
      end

      RESULT: begin
        if (flash_cnt_q == FLS_LAST) begin
          state_d      = IDLE;
          active_box_d = 3'd0;
          result_hit_d = 1'b0;
        end else begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        active_box_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset_signal) begin
      state_q      <= IDLE;
      active_box_q <= 3'd0;
      // All-ones so pads held through reset never look like a fresh edge.
      hit_prev_q   <= 5'b11111;
      win_cnt_q    <= '0;
      flash_cnt_q  <= '0;
      result_hit_q <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      active_box_q <= active_box_d;
      hit_prev_q   <= hit_prev_d;
      win_cnt_q    <= win_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      result_hit_q <= result_hit_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      score_q      <= score_d;
    end
  end

  assign box_ready    = (state_q == IDLE);
  assign active_box   = active_box_q;
  assign result_valid = (state_q == RESULT);
  assign result_hit   = result_hit_q;
  assign hit_pulse    = hit_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign score        = score_q;

endmodule
